// File: rtl/tdes_pkg.sv
// Shared definitions for the Triple-DES pass sequencer.
// Contents: default block/key widths, FSM state encoding, pass indices.
// Imported by tdes_sequencer and tdes_watchdog.
package tdes_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int KEY_W_DEF  = 56;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   // Pass 0 and 2 use key1 with the requested mode; pass 1 uses key2 with the
   // inverted mode.
   localparam logic [1:0] PASS_OUTER0 = 2'd0;
   localparam logic [1:0] PASS_MID    = 2'd1;
   localparam logic [1:0] PASS_OUTER1 = 2'd2;

endpackage

// File: rtl/tdes_watchdog.sv
// Hang watchdog: counts cycles while enabled, flags expiry on the TIMEOUT-th.
// Ports: clr restarts the count, en counts (8-bit, saturating), expired is
// combinational and only asserted while en is high.
module tdes_watchdog
   import tdes_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [7:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 8'd0;
      end else if (clr) begin
         cnt <= 8'd0;
      end else if (en && cnt != 8'hFF) begin
         cnt <= cnt + 8'd1;
      end
   end

   // cnt holds the number of completed enabled cycles, so the TIMEOUT-th
   // enabled cycle is the one where cnt == TIMEOUT-1.
   assign expired = en && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/tdes_sequencer.sv
// Triple-DES pass sequencer driving one shared iterative DES core.
// Ports: host request stream (in_*), host result stream (out_*), status
// (busy, pass_idx) and the core interface (des_*). Encrypt = EDE, decrypt = DED.
module tdes_sequencer
   import tdes_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int KEY_W   = KEY_W_DEF,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_e,
   input  logic [KEY_W-1:0]  in_key1,
   input  logic [KEY_W-1:0]  in_key2,
   input  logic [DATA_W-1:0] in_text,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_text,
   output logic              out_err,
   output logic              busy,
   output logic [1:0]        pass_idx,
   output logic              des_start,
   output logic [DATA_W-1:0] des_in,
   output logic [KEY_W-1:0]  des_key,
   output logic              des_e,
   input  logic              des_done,
   input  logic [DATA_W-1:0] des_out
);

   state_t            state;
   logic [1:0]        pass;
   logic              e_q;
   logic [KEY_W-1:0]  key1_q;
   logic [KEY_W-1:0]  key2_q;
   logic [DATA_W-1:0] blk;
   logic              wd_expired;
   logic [1:0]        pass_nxt;

   assign in_ready = (state == ST_IDLE);
   assign busy     = (state != ST_IDLE);
   assign pass_idx = pass;
   assign pass_nxt = pass + 2'd1;

   tdes_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (state == ST_ISSUE),
      .en      (state == ST_WAIT),
      .expired (wd_expired)
   );

   // Core inputs are loaded on the edge that enters ISSUE, so des_start and
   // the matching des_in/des_key/des_e are all visible during the ISSUE cycle
   // and then held through WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         pass      <= PASS_OUTER0;
         e_q       <= 1'b0;
         key1_q    <= '0;
         key2_q    <= '0;
         blk       <= '0;
         des_start <= 1'b0;
         des_in    <= '0;
         des_key   <= '0;
         des_e     <= 1'b0;
         out_valid <= 1'b0;
         out_err   <= 1'b0;
         out_text  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  e_q       <= in_e;
                  key1_q    <= in_key1;
                  key2_q    <= in_key2;
                  blk       <= in_text;
                  pass      <= PASS_OUTER0;
                  des_start <= 1'b1;
                  des_in    <= in_text;
                  des_key   <= in_key1;
                  des_e     <= in_e;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               des_start <= 1'b0;
               state     <= ST_WAIT;
            end
            ST_WAIT: begin
               // A done in the expiry cycle still counts as success.
               if (des_done) begin
                  blk <= des_out;
                  if (pass == PASS_OUTER1) begin
                     pass      <= PASS_OUTER0;
                     out_valid <= 1'b1;
                     out_err   <= 1'b0;
                     out_text  <= des_out;
                     state     <= ST_OUT;
                  end else begin
                     pass      <= pass_nxt;
                     des_start <= 1'b1;
                     des_in    <= des_out;
                     des_key   <= (pass_nxt == PASS_MID) ? key2_q : key1_q;
                     des_e     <= (pass_nxt == PASS_MID) ? ~e_q : e_q;
                     state     <= ST_ISSUE;
                  end
               end else if (wd_expired) begin
                  // Abort without exposing any intermediate block.
                  pass      <= PASS_OUTER0;
                  out_valid <= 1'b1;
                  out_err   <= 1'b1;
                  out_text  <= '0;
                  state     <= ST_OUT;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  // Scrub key material and data on leaving.
                  key1_q    <= '0;
                  key2_q    <= '0;
                  blk       <= '0;
                  des_key   <= '0;
                  des_in    <= '0;
                  out_valid <= 1'b0;
                  out_err   <= 1'b0;
                  out_text  <= '0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tdes_sequencer.sv
module tb_tdes_sequencer;
   import tdes_pkg::*;

   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_e = 1'b0;
   logic [55:0] in_key1 = '0;
   logic [55:0] in_key2 = '0;
   logic [63:0] in_text = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_text;
   logic        out_err;
   logic        busy;
   logic [1:0]  pass_idx;
   logic        des_start;
   logic [63:0] des_in;
   logic [55:0] des_key;
   logic        des_e;
   logic        des_done;
   logic [63:0] des_out;

   tdes_sequencer #(.DATA_W(64), .KEY_W(56), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_e(in_e),
      .in_key1(in_key1), .in_key2(in_key2), .in_text(in_text),
      .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
      .out_err(out_err), .busy(busy), .pass_idx(pass_idx),
      .des_start(des_start), .des_in(des_in), .des_key(des_key),
      .des_e(des_e), .des_done(des_done), .des_out(des_out)
   );

   always #5 clk = ~clk;

   // ---------------- mock DES core ----------------
   int          cyc = 0;
   int          lat = 16;
   int          hang_pass = -1;   // absolute start number that never completes
   int          mcnt = 0;
   logic        mock_done = 1'b0;
   logic        stray_done = 1'b0;
   logic [63:0] mock_out = '0;
   logic [55:0] dk_log[$];
   logic        de_log[$];
   int          st_log[$];

   assign des_done = mock_done | stray_done;
   assign des_out  = mock_out;

   always @(posedge clk) begin
      cyc       <= cyc + 1;
      mock_done <= 1'b0;
      if (des_start) begin
         mock_out <= des_e ? des_in + {8'h0, des_key} : des_in - {8'h0, des_key};
         if (st_log.size() == hang_pass) mcnt <= 0;
         else if (lat == 1) begin mock_done <= 1'b1; mcnt <= 0; end
         else mcnt <= lat - 1;
         dk_log.push_back(des_key);
         de_log.push_back(des_e);
         st_log.push_back(cyc);
      end else if (mcnt != 0) begin
         mcnt      <= mcnt - 1;
         mock_done <= (mcnt == 1);
      end
   end

   // ---------------- checking ----------------
   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_tdes(input logic e, input logic [55:0] k1,
                                            input logic [55:0] k2, input logic [63:0] t);
      logic [63:0] a, b;
      a = {8'h0, k1};
      b = {8'h0, k2};
      return e ? (t + a - b + a) : (t - a + b - a);
   endfunction

   // Issues one request and waits for the result; out_ready is left as is.
   task automatic run_txn(input string name, input logic e, input logic [55:0] k1,
                          input logic [55:0] k2, input logic [63:0] t, input int l,
                          input logic [63:0] exp_t, input logic exp_err,
                          input int exp_lat, output int b_cyc);
      int  a_cyc;
      bit  seen;
      lat = l;
      seen = 0;
      for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
      in_e = e; in_key1 = k1; in_key2 = k2; in_text = t; in_valid = 1'b1;
      check({name, "_in_ready"}, {63'h0, in_ready}, 64'h1);
      a_cyc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      check({name, "_busy"}, {62'h0, busy, in_ready}, 64'h2);
      b_cyc = cyc;
      for (int i = 0; i < 3000; i++) begin
         if (out_valid) begin seen = 1; b_cyc = cyc; break; end
         @(negedge clk);
      end
      check({name, "_done_seen"}, {63'h0, seen}, 64'h1);
      check({name, "_text"}, out_text, exp_t);
      check({name, "_err"}, {63'h0, out_err}, {63'h0, exp_err});
      if (exp_lat >= 0) check({name, "_latency"}, 64'(b_cyc - a_cyc), 64'(exp_lat));
      if (out_ready) @(negedge clk);
   endtask

   typedef struct {
      logic        e;
      logic [55:0] k1;
      logic [55:0] k2;
      logic [63:0] txt;
      int          l;
      logic [63:0] exp;
   } vec_t;

   vec_t vt[6];

   initial begin
      int b, base, sbase;
      bit ok;
      logic        re;
      logic [55:0] rk1, rk2;
      logic [63:0] rt;

      vt[0] = '{1'b1, 56'h5, 56'h3, 64'h10, 16, 64'h17};
      vt[1] = '{1'b0, 56'h5, 56'h3, 64'h17, 16, 64'h10};
      vt[2] = '{1'b1, 56'h5, 56'h3, 64'h10, 1, 64'h17};
      vt[3] = '{1'b0, 56'h5, 56'h3, 64'h0, 3, 64'hFFFF_FFFF_FFFF_FFF9};
      vt[4] = '{1'b1, 56'hFF_FFFF_FFFF_FFFF, 56'h0, 64'h0, 2, 64'h01FF_FFFF_FFFF_FFFE};
      vt[5] = '{1'b1, 56'h1, 56'h2, 64'hFFFF_FFFF_FFFF_FFFF, 5, 64'hFFFF_FFFF_FFFF_FFFF};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_flags", {56'h0, in_ready, out_valid, out_err, des_start, des_e, busy, pass_idx},
            64'h80);
      check("rst_out_text", out_text, 64'h0);
      check("rst_des_in", des_in, 64'h0);
      check("rst_des_key", {8'h0, des_key}, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors with pass key/mode sequence checks
      for (int i = 0; i < 6; i++) begin
         base = dk_log.size();
         run_txn($sformatf("vec%0d", i), vt[i].e, vt[i].k1, vt[i].k2, vt[i].txt, vt[i].l,
                 vt[i].exp, 1'b0, 3 * vt[i].l + 4, b);
         if (dk_log.size() < base + 3) check($sformatf("vec%0d_starts", i),
                                             64'(dk_log.size() - base), 64'd3);
         else begin
            check($sformatf("vec%0d_key0", i), {8'h0, dk_log[base]},   {8'h0, vt[i].k1});
            check($sformatf("vec%0d_key1", i), {8'h0, dk_log[base+1]}, {8'h0, vt[i].k2});
            check($sformatf("vec%0d_key2", i), {8'h0, dk_log[base+2]}, {8'h0, vt[i].k1});
            check($sformatf("vec%0d_eseq", i), {61'h0, de_log[base], de_log[base+1], de_log[base+2]},
                  {61'h0, vt[i].e, ~vt[i].e, vt[i].e});
         end
      end

      // Randomized against the reference model
      for (int i = 0; i < 20; i++) begin
         re  = 1'($urandom);
         rk1 = {24'($urandom), $urandom};
         rk2 = {24'($urandom), $urandom};
         rt  = {$urandom, $urandom};
         run_txn($sformatf("rnd%0d", i), re, rk1, rk2, rt, int'($urandom_range(1, 8)),
                 ref_tdes(re, rk1, rk2, rt), 1'b0, -1, b);
      end

      // Backpressure: result held, new requests ignored, keys scrubbed after
      out_ready = 1'b0;
      run_txn("bp", 1'b1, 56'h5, 56'h3, 64'h10, 4, 64'h17, 1'b0, -1, b);
      sbase = st_log.size();
      in_valid = 1'b1; in_text = 64'hDEAD; in_e = 1'b0;
      ok = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_text !== 64'h17 || !out_valid || in_ready) ok = 0;
      end
      check("bp_stable", {63'h0, ok}, 64'h1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_in_ready", {63'h0, in_ready}, 64'h1);
      check("bp_key1_scrub", {8'h0, dut.key1_q}, 64'h0);
      check("bp_key2_scrub", {8'h0, dut.key2_q}, 64'h0);
      check("bp_blk_scrub", dut.blk, 64'h0);
      check("bp_des_io_scrub", des_in | {8'h0, des_key}, 64'h0);
      check("bp_no_new_start", 64'(st_log.size() - sbase), 64'h0);

      // Watchdog: pass 1 never completes
      sbase = st_log.size();
      hang_pass = sbase + 1;
      run_txn("wd", 1'b1, 56'h5, 56'h3, 64'h10, 16, 64'h0, 1'b1, -1, b);
      hang_pass = -1;
      if (st_log.size() < sbase + 2) check("wd_starts", 64'(st_log.size() - sbase), 64'd2);
      else check("wd_delay", 64'(b - st_log[sbase+1]), 64'(TMO + 1));
      run_txn("wd_next", 1'b1, 56'h5, 56'h3, 64'h10, 16, 64'h17, 1'b0, -1, b);

      // Done coincident with the expiry cycle is success; one cycle later is abort
      run_txn("coinc", 1'b1, 56'h5, 56'h3, 64'h10, TMO, 64'h17, 1'b0, 3 * TMO + 4, b);
      run_txn("late", 1'b1, 56'h5, 56'h3, 64'h10, TMO + 1, 64'h0, 1'b1, -1, b);
      repeat (4) @(negedge clk);

      // Stray done in IDLE
      sbase = st_log.size();
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      @(negedge clk);
      check("stray_state", {56'h0, busy, out_valid, des_start, 5'h0}, 64'h0);
      check("stray_no_start", 64'(st_log.size() - sbase), 64'h0);
      run_txn("stray_next", 1'b0, 56'h5, 56'h3, 64'h17, 2, 64'h10, 1'b0, 3 * 2 + 4, b);

      // Reset during WAIT of pass 1, then the core's late done
      sbase = st_log.size();
      lat = 16;
      in_e = 1'b1; in_key1 = 56'h5; in_key2 = 56'h3; in_text = 64'h10; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 200 && st_log.size() < sbase + 2; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mrst_flags", {56'h0, in_ready, out_valid, out_err, des_start, des_e, busy, pass_idx},
            64'h80);
      check("mrst_state", {62'h0, dut.state}, {62'h0, ST_IDLE});
      check("mrst_des", des_in | {8'h0, des_key} | out_text, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid || busy || des_start) ok = 0;
      end
      check("mrst_spurious_ignored", {63'h0, ok}, 64'h1);
      run_txn("mrst_next", 1'b1, 56'h5, 56'h3, 64'h10, 16, 64'h17, 1'b0, 3 * 16 + 4, b);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
